// File: rtl/gpr_issue_scoreboard_if.sv
// Issue-side bundle of the GPR scoreboard: decoded pair in, grants/busy/stall counters out.
interface gpr_issue_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int AW       = 5,
    parameter int LAT_W    = 3,
    parameter int STALL_W  = 16
);
    logic                flush;
    logic                issue_ready;
    logic                i1_valid;
    logic [AW-1:0]       i1_src1, i1_src2, i1_dst;
    logic                i1_wen;
    logic [LAT_W-1:0]    i1_lat;
    logic                i2_valid;
    logic [AW-1:0]       i2_src1, i2_src2, i2_dst;
    logic                i2_wen;
    logic [LAT_W-1:0]    i2_lat;
    logic                i1_issue;
    logic                i2_issue;
    logic [NUM_REGS-1:0] busy_vec;
    logic [STALL_W-1:0]  stall_cycles;

    modport master (
        output flush, issue_ready,
        output i1_valid, i1_src1, i1_src2, i1_dst, i1_wen, i1_lat,
        output i2_valid, i2_src1, i2_src2, i2_dst, i2_wen, i2_lat,
        input  i1_issue, i2_issue, busy_vec, stall_cycles
    );

    modport slave (
        input  flush, issue_ready,
        input  i1_valid, i1_src1, i1_src2, i1_dst, i1_wen, i1_lat,
        input  i2_valid, i2_src1, i2_src2, i2_dst, i2_wen, i2_lat,
        output i1_issue, i2_issue, busy_vec, stall_cycles
    );
endinterface

// File: rtl/gpr_issue_scoreboard.sv
// Dual-issue GPR hazard scoreboard: per-register latency countdown, RAW/WAW/intra-pair
// blocking, in-order pair grant and a saturating stall-cycle counter.
module gpr_sb_cnt #(
    parameter int LAT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             set,
    input  logic [LAT_W-1:0] lat,
    output logic [LAT_W-1:0] cnt
);
    // A freshly loaded latency is not decremented in its load cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)            cnt <= '0;
        else if (flush)       cnt <= '0;
        else if (set)         cnt <= lat;
        else if (cnt != '0)   cnt <= cnt - LAT_W'(1);
    end
endmodule

module gpr_issue_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int AW       = 5,
    parameter int LAT_W    = 3,
    parameter int STALL_W  = 16
) (
    input logic                  clock,
    input logic                  reset,
    gpr_issue_scoreboard_if.slave sb
);
    logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
    logic [NUM_REGS-1:0]            pend;
    logic                           haz1, haz2, pair;
    logic                           stall_inc;
    logic [STALL_W-1:0]             stall_q;

    function automatic logic haz(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                                 input logic [AW-1:0] d, input logic wen,
                                 input logic [NUM_REGS-1:0] p);
        return (s1 != '0 && p[s1]) || (s2 != '0 && p[s2]) || (wen && d != '0 && p[d]);
    endfunction

    assign cnt[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic hit1, hit2;
        assign hit1 = sb.i1_issue && sb.i1_wen && sb.i1_dst == AW'(r);
        assign hit2 = sb.i2_issue && sb.i2_wen && sb.i2_dst == AW'(r);
        gpr_sb_cnt #(.LAT_W(LAT_W)) u_cnt (
            .clock (clock),
            .reset (reset),
            .flush (sb.flush),
            .set   (hit1 || hit2),
            .lat   (hit1 ? sb.i1_lat : sb.i2_lat),
            .cnt   (cnt[r])
        );
    end

    always_comb begin
        pend = '0;
        for (int r = 0; r < NUM_REGS; r++) pend[r] = (cnt[r] != '0);
    end

    assign haz1 = haz(sb.i1_src1, sb.i1_src2, sb.i1_dst, sb.i1_wen, pend);
    assign haz2 = haz(sb.i2_src1, sb.i2_src2, sb.i2_dst, sb.i2_wen, pend);
    // Slot 2 may not consume or overwrite slot 1's destination within the same pair.
    assign pair = sb.i1_wen && sb.i1_dst != '0 &&
                  (sb.i1_dst == sb.i2_src1 || sb.i1_dst == sb.i2_src2 ||
                   (sb.i2_wen && sb.i1_dst == sb.i2_dst));

    assign sb.i1_issue = sb.i1_valid && sb.issue_ready && !sb.flush && !reset && !haz1;
    assign sb.i2_issue = sb.i1_issue && sb.i2_valid && !haz2 && !pair;

    // cnt is the register state, so its pending view is already post-update.
    assign sb.busy_vec = pend;

    assign stall_inc = sb.i1_valid && sb.issue_ready && !sb.flush && !sb.i1_issue;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                          stall_q <= '0;
        else if (stall_inc && stall_q != '1) stall_q <= stall_q + STALL_W'(1);
    end

    assign sb.stall_cycles = stall_q;
endmodule

// File: tb/tb_gpr_issue_scoreboard.sv
// Directed bench for gpr_issue_scoreboard: one task per scenario, hand-computed expectations.
module tb_gpr_issue_scoreboard;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int LW = 3;
    localparam int SW = 10;

    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    gpr_issue_scoreboard_if #(.NUM_REGS(NR), .AW(AW), .LAT_W(LW), .STALL_W(SW)) sb ();

    gpr_issue_scoreboard #(.NUM_REGS(NR), .AW(AW), .LAT_W(LW), .STALL_W(SW)) dut (
        .clock (clock),
        .reset (reset),
        .sb    (sb.slave)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_i1(input logic v, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                          input logic [AW-1:0] d, input logic w, input logic [LW-1:0] l);
        sb.i1_valid = v; sb.i1_src1 = s1; sb.i1_src2 = s2;
        sb.i1_dst = d; sb.i1_wen = w; sb.i1_lat = l;
    endtask

    task automatic set_i2(input logic v, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                          input logic [AW-1:0] d, input logic w, input logic [LW-1:0] l);
        sb.i2_valid = v; sb.i2_src1 = s1; sb.i2_src2 = s2;
        sb.i2_dst = d; sb.i2_wen = w; sb.i2_lat = l;
    endtask

    task automatic idle();
        sb.flush = 1'b0;
        sb.issue_ready = 1'b1;
        set_i1(1'b0, '0, '0, '0, 1'b0, '0);
        set_i2(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        set_i1(1'b1, '0, '0, '0, 1'b0, '0);
        #2;
        n_tests++; if (sb.i1_issue !== 1'b0) begin n_fail++; $display("FAIL reset_issue got %b exp 0", sb.i1_issue); end
        n_tests++; if (sb.busy_vec !== '0) begin n_fail++; $display("FAIL reset_busy got %h exp 0", sb.busy_vec); end
        n_tests++; if (sb.stall_cycles !== '0) begin n_fail++; $display("FAIL reset_stall got %0d exp 0", sb.stall_cycles); end
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        n_tests++; if (sb.i1_issue !== 1'b1) begin n_fail++; $display("FAIL release_issue got %b exp 1", sb.i1_issue); end
        idle();
        tick();
    endtask

    task automatic test_raw();
        set_i1(1'b1, '0, '0, 5'd5, 1'b1, 3'd3);
        #1;
        n_tests++; if (sb.i1_issue !== 1'b1) begin n_fail++; $display("FAIL raw_producer got %b exp 1", sb.i1_issue); end
        tick();
        set_i1(1'b1, 5'd5, '0, '0, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++; if (sb.i1_issue !== 1'b0) begin n_fail++; $display("FAIL raw_stall%0d got %b exp 0", k, sb.i1_issue); end
            n_tests++; if (sb.busy_vec[5] !== 1'b1) begin n_fail++; $display("FAIL raw_busy%0d got %b exp 1", k, sb.busy_vec[5]); end
            tick();
        end
        #1;
        n_tests++; if (sb.i1_issue !== 1'b1) begin n_fail++; $display("FAIL raw_release got %b exp 1", sb.i1_issue); end
        n_tests++; if (sb.busy_vec[5] !== 1'b0) begin n_fail++; $display("FAIL raw_busy_clear got %b exp 0", sb.busy_vec[5]); end
        n_tests++; if (sb.stall_cycles !== SW'(3)) begin n_fail++; $display("FAIL raw_stall_cnt got %0d exp 3", sb.stall_cycles); end
        idle();
        tick();
    endtask

    task automatic test_pair();
        set_i1(1'b1, '0, '0, 5'd7, 1'b1, 3'd2);
        set_i2(1'b1, '0, 5'd7, '0, 1'b0, '0);
        #1;
        n_tests++; if ({sb.i1_issue, sb.i2_issue} !== 2'b10) begin n_fail++; $display("FAIL pair_raw got %b exp 10", {sb.i1_issue, sb.i2_issue}); end
        sb.i1_dst = '0;
        #1;
        n_tests++; if ({sb.i1_issue, sb.i2_issue} !== 2'b11) begin n_fail++; $display("FAIL pair_r0 got %b exp 11", {sb.i1_issue, sb.i2_issue}); end
        tick();
        idle();
        #1;
        n_tests++; if (sb.busy_vec !== '0) begin n_fail++; $display("FAIL pair_r0_busy got %h exp 0", sb.busy_vec); end
    endtask

    task automatic test_waw();
        set_i1(1'b1, '0, '0, 5'd9, 1'b1, 3'd2);
        set_i2(1'b1, '0, '0, 5'd9, 1'b1, 3'd1);
        #1;
        n_tests++; if ({sb.i1_issue, sb.i2_issue} !== 2'b10) begin n_fail++; $display("FAIL waw_pair got %b exp 10", {sb.i1_issue, sb.i2_issue}); end
        tick();
        set_i1(1'b1, '0, '0, '0, 1'b0, '0);
        set_i2(1'b1, '0, '0, 5'd9, 1'b1, 3'd1);
        #1;
        n_tests++; if ({sb.i1_issue, sb.i2_issue} !== 2'b10) begin n_fail++; $display("FAIL waw_pending got %b exp 10", {sb.i1_issue, sb.i2_issue}); end
        n_tests++; if (sb.busy_vec !== 32'h0000_0200) begin n_fail++; $display("FAIL waw_busy got %h exp 00000200", sb.busy_vec); end
        tick();
        idle();
        tick();
        n_tests++; if (sb.busy_vec !== '0) begin n_fail++; $display("FAIL waw_drain got %h exp 0", sb.busy_vec); end
    endtask

    task automatic test_flush();
        set_i1(1'b1, '0, '0, 5'd3, 1'b1, 3'd5);
        set_i2(1'b1, '0, '0, 5'd4, 1'b1, 3'd2);
        #1;
        n_tests++; if ({sb.i1_issue, sb.i2_issue} !== 2'b11) begin n_fail++; $display("FAIL flush_setup got %b exp 11", {sb.i1_issue, sb.i2_issue}); end
        tick();
        n_tests++; if (sb.busy_vec !== 32'h0000_0018) begin n_fail++; $display("FAIL flush_busy_pre got %h exp 00000018", sb.busy_vec); end
        sb.flush = 1'b1;
        set_i1(1'b1, '0, '0, '0, 1'b0, '0);
        set_i2(1'b1, '0, '0, '0, 1'b0, '0);
        #1;
        n_tests++; if ({sb.i1_issue, sb.i2_issue} !== 2'b00) begin n_fail++; $display("FAIL flush_grant got %b exp 00", {sb.i1_issue, sb.i2_issue}); end
        tick();
        idle();
        #1;
        n_tests++; if (sb.busy_vec !== '0) begin n_fail++; $display("FAIL flush_busy_post got %h exp 0", sb.busy_vec); end
        n_tests++; if (sb.stall_cycles !== SW'(3)) begin n_fail++; $display("FAIL flush_stall got %0d exp 3", sb.stall_cycles); end
        set_i1(1'b1, 5'd3, 5'd4, '0, 1'b0, '0);
        #1;
        n_tests++; if (sb.i1_issue !== 1'b1) begin n_fail++; $display("FAIL flush_reuse got %b exp 1", sb.i1_issue); end
        idle();
        tick();
    endtask

    task automatic test_not_ready();
        set_i1(1'b1, '0, '0, 5'd6, 1'b1, 3'd2);
        tick();
        sb.issue_ready = 1'b0;
        set_i1(1'b1, '0, '0, '0, 1'b0, '0);
        #1;
        n_tests++; if (sb.i1_issue !== 1'b0) begin n_fail++; $display("FAIL nr_grant got %b exp 0", sb.i1_issue); end
        tick();
        n_tests++; if (sb.busy_vec[6] !== 1'b1) begin n_fail++; $display("FAIL nr_busy got %b exp 1", sb.busy_vec[6]); end
        n_tests++; if (sb.stall_cycles !== SW'(3)) begin n_fail++; $display("FAIL nr_stall got %0d exp 3", sb.stall_cycles); end
        tick();
        n_tests++; if (sb.busy_vec[6] !== 1'b0) begin n_fail++; $display("FAIL nr_drain got %b exp 0", sb.busy_vec[6]); end
        idle();
    endtask

    task automatic test_back_to_back();
        set_i1(1'b1, '0, '0, 5'd10, 1'b1, 3'd0);
        tick();
        set_i1(1'b1, 5'd10, '0, 5'd11, 1'b1, 3'd1);
        #1;
        n_tests++; if (sb.i1_issue !== 1'b1) begin n_fail++; $display("FAIL b2b_lat0 got %b exp 1", sb.i1_issue); end
        n_tests++; if (sb.busy_vec !== '0) begin n_fail++; $display("FAIL b2b_busy got %h exp 0", sb.busy_vec); end
        tick();
        set_i1(1'b1, 5'd11, '0, '0, 1'b0, '0);
        #1;
        n_tests++; if (sb.i1_issue !== 1'b0) begin n_fail++; $display("FAIL b2b_lat1_stall got %b exp 0", sb.i1_issue); end
        tick();
        n_tests++; if (sb.i1_issue !== 1'b1) begin n_fail++; $display("FAIL b2b_lat1_go got %b exp 1", sb.i1_issue); end
        n_tests++; if (sb.stall_cycles !== SW'(4)) begin n_fail++; $display("FAIL b2b_stall got %0d exp 4", sb.stall_cycles); end
        idle();
        tick();
    endtask

    task automatic test_saturation();
        set_i1(1'b1, '0, '0, '0, 1'b1, 3'd7);
        #1;
        n_tests++; if (sb.i1_issue !== 1'b1) begin n_fail++; $display("FAIL r0_issue got %b exp 1", sb.i1_issue); end
        tick();
        n_tests++; if (sb.busy_vec !== '0) begin n_fail++; $display("FAIL r0_busy got %h exp 0", sb.busy_vec); end
        // Self-dependent producer: 7 stall cycles per grant, well past 2**SW stalls in total.
        set_i1(1'b1, 5'd12, '0, 5'd12, 1'b1, 3'd7);
        for (int k = 0; k < 2 * (1 << SW); k++) tick();
        n_tests++; if (sb.stall_cycles !== {SW{1'b1}}) begin n_fail++; $display("FAIL sat_stall got %0d exp %0d", sb.stall_cycles, (1 << SW) - 1); end
        set_i1(1'b1, 5'd12, '0, '0, 1'b0, '0);
        #1;
        reset = 1'b1;
        #1;
        n_tests++; if (sb.busy_vec !== '0) begin n_fail++; $display("FAIL midreset_busy got %h exp 0", sb.busy_vec); end
        n_tests++; if (sb.stall_cycles !== '0) begin n_fail++; $display("FAIL midreset_stall got %0d exp 0", sb.stall_cycles); end
        #1;
        reset = 1'b0;
        #1;
        n_tests++; if (sb.i1_issue !== 1'b1) begin n_fail++; $display("FAIL midreset_issue got %b exp 1", sb.i1_issue); end
        idle();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_pair();
        test_waw();
        test_flush();
        test_not_ready();
        test_back_to_back();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
